// File: rtl/md5_batch_sequencer_if.sv
// Host-side channels of md5_batch_sequencer: batch command, batch byte stream,
// result record and matched-string stream. The sequencer uses the slave modport.
interface md5_batch_sequencer_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [31:0]  cmd_num_bytes;
   logic [15:0]  cmd_str_len;
   logic [127:0] cmd_target_hash;

   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;

   logic         res_valid;
   logic         res_ready;
   logic         res_match;
   logic         res_error;
   logic [31:0]  res_byte_pos;

   logic [7:0]   str_data;
   logic         str_valid;
   logic         str_ready;
   logic         str_last;

   modport master (
      output cmd_valid, cmd_num_bytes, cmd_str_len, cmd_target_hash,
      output in_data, in_valid,
      output res_ready,
      output str_ready,
      input  cmd_ready, in_ready,
      input  res_valid, res_match, res_error, res_byte_pos,
      input  str_data, str_valid, str_last
   );

   modport slave (
      input  cmd_valid, cmd_num_bytes, cmd_str_len, cmd_target_hash,
      input  in_data, in_valid,
      input  res_ready,
      input  str_ready,
      output cmd_ready, in_ready,
      output res_valid, res_match, res_error, res_byte_pos,
      output str_data, str_valid, str_last
   );
endinterface

// File: rtl/md5_batch_sequencer.sv
// Sequences one batch through a string_process_match/MD5 core: command latch,
// byte feed, completion/timeout wait, result record and matched-string unload.
module md5_batch_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   md5_batch_sequencer_if.slave host,
   output logic                 busy,
   output logic                 proc_start,
   output logic [31:0]          proc_num_bytes,
   output logic [15:0]          proc_str_len,
   output logic [127:0]         proc_target_hash,
   output logic [7:0]           proc_data,
   output logic                 proc_data_valid,
   output logic                 proc_match_char_next,
   input  logic                 proc_done,
   input  logic                 proc_match,
   input  logic [31:0]          proc_byte_pos,
   input  logic [7:0]           proc_match_char
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      FEED,
      WAIT_DONE,
      REPORT,
      DRAIN
   } state_t;

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t       state;
   state_t       next_state;

   logic         cmd_ready_q;
   logic [31:0]  bytes_left;
   logic [31:0]  timer;
   logic [5:0]   nchar;
   logic [5:0]   char_cnt;
   logic         res_match_q;
   logic         res_error_q;
   logic [31:0]  res_byte_pos_q;

   logic         cmd_fire;
   logic         len_legal;
   logic         in_fire;
   logic         res_fire;
   logic         str_fire;
   logic         timed_out;
   logic         last_char;

   assign cmd_fire  = (state == IDLE) && cmd_ready_q && host.cmd_valid;
   assign len_legal = (host.cmd_str_len != 16'd0) &&
                      (host.cmd_str_len <= 16'd440) &&
                      (host.cmd_str_len[2:0] == 3'b000);
   assign in_fire   = (state == FEED) && host.in_valid;
   assign res_fire  = (state == REPORT) && host.res_ready;
   assign str_fire  = (state == DRAIN) && host.str_ready;
   assign timed_out = (timer == TIMEOUT_LAST);
   assign last_char = (char_cnt == (nchar - 6'd1));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; proc_done beats the timeout when both land on one edge
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (cmd_fire) begin
               next_state = len_legal ? START : REPORT;
            end
         end
         START: begin
            next_state = (proc_num_bytes == 32'd0) ? WAIT_DONE : FEED;
         end
         FEED: begin
            if (in_fire && (bytes_left == 32'd1)) begin
               next_state = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (proc_done || timed_out) begin
               next_state = REPORT;
            end
         end
         REPORT: begin
            if (res_fire) begin
               next_state = res_match_q ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (str_fire && last_char) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Command latch, byte feed, timeout counter and result capture.
   // cmd_ready is registered so it reads 0 while reset is held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_ready_q      <= 1'b0;
         proc_num_bytes   <= 32'd0;
         proc_str_len     <= 16'd0;
         proc_target_hash <= 128'd0;
         proc_data        <= 8'd0;
         proc_data_valid  <= 1'b0;
         bytes_left       <= 32'd0;
         timer            <= 32'd0;
         nchar            <= 6'd0;
         char_cnt         <= 6'd0;
         res_match_q      <= 1'b0;
         res_error_q      <= 1'b0;
         res_byte_pos_q   <= 32'd0;
      end else begin
         cmd_ready_q     <= (next_state == IDLE);
         proc_data_valid <= in_fire;
         timer           <= (state == WAIT_DONE) ? (timer + 32'd1) : 32'd0;
         if (in_fire) begin
            proc_data <= host.in_data;
         end
         unique case (state)
            IDLE: begin
               if (cmd_fire) begin
                  proc_num_bytes   <= host.cmd_num_bytes;
                  proc_str_len     <= host.cmd_str_len;
                  proc_target_hash <= host.cmd_target_hash;
                  nchar            <= host.cmd_str_len[8:3];
                  char_cnt         <= 6'd0;
                  if (!len_legal) begin
                     res_error_q    <= 1'b1;
                     res_match_q    <= 1'b0;
                     res_byte_pos_q <= 32'd0;
                  end
               end
            end
            START: begin
               bytes_left <= proc_num_bytes;
            end
            FEED: begin
               if (in_fire) begin
                  bytes_left <= bytes_left - 32'd1;
               end
            end
            WAIT_DONE: begin
               if (proc_done) begin
                  res_match_q    <= proc_match;
                  res_byte_pos_q <= proc_byte_pos;
                  res_error_q    <= 1'b0;
               end else if (timed_out) begin
                  res_match_q    <= 1'b0;
                  res_byte_pos_q <= 32'd0;
                  res_error_q    <= 1'b1;
               end
            end
            DRAIN: begin
               if (str_fire) begin
                  char_cnt <= char_cnt + 6'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign host.cmd_ready    = cmd_ready_q;
   assign host.in_ready     = (state == FEED);
   assign host.res_valid    = (state == REPORT);
   assign host.res_match    = res_match_q;
   assign host.res_error    = res_error_q;
   assign host.res_byte_pos = res_byte_pos_q;

   // The matched string is passed straight through from the matcher's shift register
   assign host.str_valid    = (state == DRAIN);
   assign host.str_data     = (state == DRAIN) ? proc_match_char : 8'd0;
   assign host.str_last     = (state == DRAIN) && last_char;

   assign busy                 = (state != IDLE);
   assign proc_start           = (state == START);
   assign proc_match_char_next = str_fire;

endmodule

// File: tb/tb_md5_batch_sequencer.sv
// Randomized bench for md5_batch_sequencer with a behavioural matcher stub
// and a result/stream reference model derived from the batch rules.
module tb_md5_batch_sequencer;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   md5_batch_sequencer_if host ();

   logic         busy;
   logic         proc_start;
   logic [31:0]  proc_num_bytes;
   logic [15:0]  proc_str_len;
   logic [127:0] proc_target_hash;
   logic [7:0]   proc_data;
   logic         proc_data_valid;
   logic         proc_match_char_next;
   logic         proc_done;
   logic         proc_match;
   logic [31:0]  proc_byte_pos;
   logic [7:0]   proc_match_char;

   md5_batch_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .host                 (host),
      .busy                 (busy),
      .proc_start           (proc_start),
      .proc_num_bytes       (proc_num_bytes),
      .proc_str_len         (proc_str_len),
      .proc_target_hash     (proc_target_hash),
      .proc_data            (proc_data),
      .proc_data_valid      (proc_data_valid),
      .proc_match_char_next (proc_match_char_next),
      .proc_done            (proc_done),
      .proc_match           (proc_match),
      .proc_byte_pos        (proc_byte_pos),
      .proc_match_char      (proc_match_char)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]   rx_q[$];
   int           rx_first = 0;
   int           rx_last = 0;
   int           stub_num = 0;
   bit           stub_armed = 0;
   bit           zero_pending = 0;
   int           wd_idx = 0;
   int           wd_start_cyc = 0;
   int           start_pulses = 0;
   int           pulse_base = 0;
   logic [31:0]  cap_num = '0;
   logic [15:0]  cap_len = '0;
   logic [127:0] cap_hash = '0;

   int           done_at = 0;
   logic         stub_match = 1'b0;
   logic [31:0]  stub_pos = '0;
   logic [7:0]   str_chars [64];

   int           next_pulses = 0;
   int           next_outside = 0;

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Matcher stub: records the byte feed, raises proc_done in the chosen
   // WAIT_DONE cycle and shifts out str_chars on proc_match_char_next.
   initial begin : matcher_stub
      bit first_wd;
      proc_done       = 1'b0;
      proc_match      = 1'b0;
      proc_byte_pos   = '0;
      proc_match_char = '0;
      forever begin
         @(posedge clk); #1;
         first_wd  = 1'b0;
         proc_done = 1'b0;
         if (!reset_n) begin
            stub_armed   = 1'b0;
            zero_pending = 1'b0;
            wd_idx       = 0;
            pulse_base   = next_pulses;
         end else begin
            if (zero_pending) begin
               first_wd     = 1'b1;
               zero_pending = 1'b0;
            end
            if (proc_start) begin
               start_pulses++;
               cap_num    = proc_num_bytes;
               cap_len    = proc_str_len;
               cap_hash   = proc_target_hash;
               stub_num   = int'(proc_num_bytes);
               stub_armed = 1'b1;
               rx_q.delete();
               pulse_base = next_pulses;
               if (proc_num_bytes == 32'd0) zero_pending = 1'b1;
            end
            if (proc_data_valid) begin
               rx_q.push_back(proc_data);
               if (rx_q.size() == 1) rx_first = cyc;
               rx_last = cyc;
               if (stub_armed && rx_q.size() == stub_num) first_wd = 1'b1;
            end
            if (first_wd) begin
               wd_idx       = 1;
               wd_start_cyc = cyc;
               stub_armed   = 1'b0;
            end else if (wd_idx > 0) begin
               wd_idx++;
            end
            if (wd_idx > 0 && wd_idx == done_at) begin
               proc_done     = 1'b1;
               proc_match    = stub_match;
               proc_byte_pos = stub_pos;
               wd_idx        = 0;
            end else begin
               proc_match    = 1'($urandom);
               proc_byte_pos = $urandom;
               if (wd_idx >= TO) wd_idx = 0;
            end
         end
         proc_match_char = str_chars[(next_pulses - pulse_base) & 63];
      end
   end

   always @(negedge clk) begin
      if (reset_n && proc_match_char_next) begin
         next_pulses <= next_pulses + 1;
         if (!host.str_valid) next_outside <= next_outside + 1;
      end
   end

   task automatic applyStimulus(input int num, input logic [15:0] len, input int done_n,
                                input bit gaps, input int stall, input bit match,
                                input logic [31:0] pos);
      logic [7:0]   sent[$];
      logic [127:0] hash;
      bit           legal, exp_done, exp_err, exp_match, hold_ok;
      int           exp_lat, nchar, idx, guard, s0, p0, res_cyc, k, bad;
      logic         seen_match, seen_err;
      logic [31:0]  seen_pos;

      legal     = (len != 0) && (len <= 440) && (len % 8 == 0);
      exp_done  = (done_n >= 1) && (done_n <= TO);
      nchar     = len / 8;
      exp_err   = !legal || !exp_done;
      exp_match = legal && exp_done && match;
      exp_lat   = exp_done ? done_n : TO;

      hash = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < num; i++) sent.push_back(8'($urandom));
      for (int i = 0; i < 64; i++) str_chars[i] = 8'($urandom);
      done_at    = done_n;
      stub_match = match;
      stub_pos   = pos;
      s0 = start_pulses;
      p0 = next_pulses;

      @(posedge clk); #1;
      host.cmd_valid       = 1'b1;
      host.cmd_num_bytes   = 32'(num);
      host.cmd_str_len     = len;
      host.cmd_target_hash = hash;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!host.cmd_ready && guard < 50);
      checkOutput("cmd_accept", host.cmd_ready, 1'b1);
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
      checkOutput("proc_start", proc_start, legal);
      checkOutput("busy", busy, 1'b1);

      if (legal && num > 0) begin
         idx = 0;
         guard = 0;
         while (idx < num && guard < 4 * num + 100) begin
            @(posedge clk); #1;
            host.in_valid = gaps ? 1'($urandom) : 1'b1;
            host.in_data  = sent[idx];
            @(negedge clk);
            guard++;
            if (host.in_valid && host.in_ready) idx++;
         end
         checkOutput("feed_count", idx, num);
         @(posedge clk); #1;
         host.in_valid = 1'b0;
         checkOutput("in_ready_drop", host.in_ready, 1'b0);
      end

      guard = 0;
      while (!host.res_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      res_cyc = cyc;
      checkOutput("res_valid_seen", host.res_valid, 1'b1);
      if (!host.res_valid) begin
         reset_n = 1'b0;
         repeat (2) @(posedge clk);
         #1 reset_n = 1'b1;
         return;
      end
      if (legal) checkOutput("res_latency", res_cyc - wd_start_cyc, exp_lat);
      checkOutput("res_error", host.res_error, exp_err);
      checkOutput("res_match", host.res_match, exp_match);
      if (!legal) checkOutput("res_byte_pos", host.res_byte_pos, 32'd0);
      else if (exp_done) checkOutput("res_byte_pos", host.res_byte_pos, pos);

      seen_match = host.res_match;
      seen_err   = host.res_error;
      seen_pos   = host.res_byte_pos;
      hold_ok    = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (!host.res_valid || host.res_match !== seen_match ||
             host.res_error !== seen_err || host.res_byte_pos !== seen_pos) hold_ok = 1'b0;
      end
      if (stall > 0) checkOutput("res_hold", hold_ok, 1'b1);
      @(posedge clk); #1;
      host.res_ready = 1'b1;
      @(negedge clk);
      checkOutput("res_valid_at_ready", host.res_valid, 1'b1);
      @(posedge clk); #1;
      host.res_ready = 1'b0;

      if (exp_match) begin
         k = 0;
         guard = 0;
         while (k < nchar && guard < 8 * nchar + 50) begin
            host.str_ready = gaps ? 1'($urandom) : 1'b1;
            @(negedge clk);
            guard++;
            if (host.str_valid && host.str_ready) begin
               checkOutput("str_data", host.str_data, str_chars[k]);
               checkOutput("str_last", host.str_last, (k == nchar - 1));
               k++;
            end
            @(posedge clk); #1;
         end
         host.str_ready = 1'b0;
         checkOutput("drain_count", k, nchar);
      end

      @(negedge clk);
      checkOutput("idle_after", {busy, host.str_valid, host.res_valid}, 3'b000);
      checkOutput("start_pulses", start_pulses - s0, legal ? 1 : 0);
      checkOutput("char_next_pulses", next_pulses - p0, exp_match ? nchar : 0);
      if (legal) begin
         checkOutput("cmd_fields", {cap_num, cap_len}, {32'(num), len});
         checkOutput("cmd_hash", cap_hash, hash);
         bad = (rx_q.size() != num) ? 1 : 0;
         for (int i = 0; i < rx_q.size() && i < num; i++) begin
            if (rx_q[i] !== sent[i]) bad++;
         end
         checkOutput("feed_bytes", bad, 0);
         if (!gaps && num > 0) checkOutput("feed_no_bubbles", rx_last - rx_first, num - 1);
      end
   endtask

   task automatic applyResetMidFeed();
      int fed;
      int guard;
      @(posedge clk); #1;
      host.cmd_valid       = 1'b1;
      host.cmd_num_bytes   = 32'd64;
      host.cmd_str_len     = 16'd152;
      host.cmd_target_hash = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
      fed = 0;
      guard = 0;
      while (fed < 10 && guard < 100) begin
         @(posedge clk); #1;
         host.in_valid = 1'b1;
         host.in_data  = 8'($urandom);
         @(negedge clk);
         guard++;
         if (host.in_ready) fed++;
      end
      checkOutput("reset_prefeed", fed, 10);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_ctrl",
                  {busy, host.cmd_ready, host.in_ready, host.res_valid, host.str_valid,
                   proc_start, proc_data_valid, proc_match_char_next}, 8'h00);
      checkOutput("async_reset_data", {proc_data, proc_num_bytes, host.res_byte_pos}, 72'h0);
      host.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_reset_cmd_ready", host.cmd_ready, 1'b1);
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      host.cmd_valid       = 1'b0;
      host.cmd_num_bytes   = '0;
      host.cmd_str_len     = '0;
      host.cmd_target_hash = '0;
      host.in_valid        = 1'b0;
      host.in_data         = '0;
      host.res_ready       = 1'b0;
      host.str_ready       = 1'b0;
      for (int i = 0; i < 64; i++) str_chars[i] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_handshakes",
                  {host.cmd_ready, host.in_ready, host.res_valid, host.str_valid,
                   busy, proc_start, proc_data_valid, proc_match_char_next}, 8'h00);
      checkOutput("reset_result", {host.res_match, host.res_error, host.res_byte_pos}, 34'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("idle_cmd_ready", host.cmd_ready, 1'b1);

      applyStimulus(64, 16'd152, 5, 1'b0, 0, 1'b1, 32'd40);
      applyStimulus(32, 16'd152, 4, 1'b0, 0, 1'b0, $urandom);
      applyStimulus(16, 16'd0, 3, 1'b0, 0, 1'b1, 32'd1);
      applyStimulus(16, 16'd448, 3, 1'b0, 0, 1'b1, 32'd1);
      applyStimulus(16, 16'd100, 3, 1'b0, 0, 1'b1, 32'd1);
      applyStimulus(16, 16'd8, 3, 1'b0, 0, 1'b1, 32'd7);
      applyStimulus(12, 16'd440, 2, 1'b0, 0, 1'b1, 32'd11);
      applyStimulus(8, 16'd64, 0, 1'b0, 0, 1'b1, 32'd3);
      applyStimulus(0, 16'd64, 0, 1'b0, 0, 1'b1, 32'd3);
      applyStimulus(8, 16'd64, TO, 1'b0, 0, 1'b1, 32'd6);
      applyStimulus(0, 16'd32, 1, 1'b0, 0, 1'b1, 32'd0);
      applyStimulus(40, 16'd88, 6, 1'b1, 10, 1'b1, $urandom);
      applyStimulus(24, 16'd440, 3, 1'b1, 10, 1'b1, $urandom);
      applyResetMidFeed();
      applyStimulus(64, 16'd152, 5, 1'b0, 0, 1'b1, 32'd40);

      for (int r = 0; r < 8; r++) begin
         int          num;
         logic [15:0] len;
         num = $urandom_range(0, 40);
         len = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 500))
                                           : 16'(8 * $urandom_range(1, 55));
         applyStimulus(num, len, $urandom_range(0, 20), 1'($urandom),
                       $urandom_range(0, 4), 1'($urandom), $urandom);
      end

      checkOutput("char_next_outside_drain", next_outside, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/md5_batch_sequencer.md
# md5_batch_sequencer

Controls one string_process_match/MD5 core. It accepts a batch command from the host and streams the batch bytes into the matcher. It waits for the matcher to finish or time out, returns a result record, and unloads the matched string one byte at a time. It sits between the host/DMA side and the matcher. It is the only driver of the matcher's `proc_*` control inputs.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles spent in WAIT_DONE before the block reports an error.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: batch command handshake.
- `cmd_num_bytes` in 32: number of bytes (hashes) in the batch.
- `cmd_str_len` in 16: string length in bits.
- `cmd_target_hash` in 128: target hash; A is in [127:96].
- `in_data` in 8, `in_valid` in 1, `in_ready` out 1: batch byte stream.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_match` out 1: a match was found.
- `res_error` out 1: illegal length or timeout.
- `res_byte_pos` out 32: hash index of the match.
- `str_data` out 8, `str_valid` out 1, `str_ready` in 1, `str_last` out 1: matched-string stream.
- `busy` out 1: high in every state except IDLE.
- `proc_start` out 1: one-cycle pulse.
- `proc_num_bytes` out 32, `proc_str_len` out 16, `proc_target_hash` out 128: latched copies of the command fields.
- `proc_data` out 8, `proc_data_valid` out 1: registered byte feed to the matcher.
- `proc_match_char_next` out 1: advances the matcher's match-string shift register.
- `proc_done`, `proc_match` in 1; `proc_byte_pos` in 32; `proc_match_char` in 8: matcher status.

## Operation
- States: IDLE, START, FEED, WAIT_DONE, REPORT, DRAIN.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch the command fields and compute `nchar` = `cmd_str_len`>>3.
  - Illegal length: `cmd_str_len` is 0, above 440, or has [2:0]≠0.
  - Illegal length → REPORT with `res_error`=1, `res_match`=0, `res_byte_pos`=0. No `proc_start` is issued.
  - Legal length → START.
- **START**
  - `proc_start`=1 for exactly one cycle.
  - Load `bytes_left`=`cmd_num_bytes`.
  - Next state is FEED, or WAIT_DONE if `num_bytes`=0.
- **FEED**
  - `in_ready`=1.
  - Each `in_valid`&`in_ready` registers `proc_data`=`in_data` and `proc_data_valid`=1 on the next cycle, then decrements `bytes_left`.
  - `proc_data_valid`=0 on every cycle without a transfer.
  - When the transfer that makes `bytes_left`=0 completes, drop `in_ready` in the same edge and go to WAIT_DONE.
- **WAIT_DONE**
  - Clear the timeout counter on entry; increment it every cycle.
  - `proc_done` is sampled only in this state.
  - `proc_done`=1 → capture `proc_match` into `res_match` and `proc_byte_pos` into `res_byte_pos`; `res_error`=0; go to REPORT.
  - Counter reaches `TIMEOUT_CYCLES` with no `proc_done` → `res_error`=1, `res_match`=0; go to REPORT.
  - If `proc_done` and the timeout occur in the same cycle, `proc_done` wins.
- **REPORT**
  - `res_valid`=1; the result fields are held stable until the handshake.
  - On `res_valid`&`res_ready`: go to DRAIN if `res_match`=1, otherwise to IDLE.
- **DRAIN**
  - `str_data`=`proc_match_char` (combinational); `str_valid`=1.
  - `str_last`=1 when `char_cnt`=`nchar`-1.
  - Each `str_valid`&`str_ready` pulses `proc_match_char_next` in the same cycle and increments `char_cnt`.
  - After the last transfer, go to IDLE.
  - `proc_match_char_next` is never asserted outside DRAIN.
- Reset values:
  - All handshake outputs, `proc_start`, `proc_data_valid`, `proc_match_char_next` and `busy` are 0.
  - All data outputs and internal counters are 0.
  - State is IDLE.
- `reset_n` asserted mid-batch aborts immediately with no result. The matcher keeps its own reset; the system resets both together.
- `in_valid` outside FEED is ignored (`in_ready`=0). `cmd_valid` outside IDLE is ignored.

## Timing
- `cmd_valid`&`cmd_ready` at edge N → `proc_start`=1 in cycle N+1.
- First FEED cycle is N+2.
- Byte accepted at edge M → `proc_data_valid`=1 in cycle M+1.
- Full-rate input gives one matcher byte per cycle with no bubbles.
- `proc_done` high at edge K → `res_valid`=1 in cycle K+1.
- DRAIN sustains one byte per cycle while `str_ready`=1.
- The `proc_match_char` update caused by `proc_match_char_next` is visible in the cycle after the pulse.

## Test plan
1. Matching batch:
   - Stimulus: `num_bytes`=64, `str_len`=152 (19 chars), target set to the hash of the string ending at byte 40, full-rate input.
   - Response: exactly 64 `proc_data_valid` pulses; `res_match`=1; `res_byte_pos`=40; 19 `str` bytes equal to the string, `str_last` on the 19th; then IDLE.
2. Non-matching batch:
   - Stimulus: `num_bytes`=32 with an unmatched target.
   - Response: `res_match`=0, `res_error`=0; no DRAIN and no `proc_match_char_next` pulses.
3. Illegal length:
   - Stimulus: `str_len`=0, 448, or 100.
   - Response: `res_error`=1 with no `proc_start`; then `str_len`=8 is accepted normally.
4. Timeout:
   - Stimulus: `TIMEOUT_CYCLES`=16, matcher model never asserts `proc_done`.
   - Response: `res_valid` appears exactly 16 cycles after WAIT_DONE entry, with `res_error`=1.
5. Backpressure and gaps:
   - Stimulus: `in_valid` toggled at random; `res_ready` held low for 10 cycles; `str_ready` toggled at random.
   - Response: no byte lost or duplicated; result fields stable while stalled; exactly `nchar` `proc_match_char_next` pulses.
6. Reset mid-FEED:
   - Stimulus: `reset_n` low at byte 10 of 64.
   - Response: all outputs return to reset values asynchronously, state is IDLE, and the next command completes normally.
